// File: rtl/pipelined_cla_adder_if.sv
// Operand/result bundle for the pipelined carry-lookahead adder/subtractor.
//
// Handshake: valid-only, no ready. When EN=1 at a rising clock edge the pipeline
// advances one stage and IN_VALID qualifies A/B/CI/SUB for that edge. When EN=0
// every stage holds and the inputs are ignored. OUT_VALID qualifies
// SUM/CO/OVF; there is no backpressure, so the consumer either samples while
// OUT_VALID=1 or drops EN.
interface pipelined_cla_adder_if #(
   parameter int WIDTH = 8
);
   logic             EN;
   logic             IN_VALID;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             CI;
   logic             SUB;
   logic [WIDTH-1:0] SUM;
   logic             CO;
   logic             OVF;
   logic             OUT_VALID;

   // Producer/consumer side that feeds operands and collects results.
   modport master (
      output EN, IN_VALID, A, B, CI, SUB,
      input  SUM, CO, OVF, OUT_VALID
   );

   // The adder itself.
   modport slave (
      input  EN, IN_VALID, A, B, CI, SUB,
      output SUM, CO, OVF, OUT_VALID
   );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined N-bit adder/subtractor built from GROUP-bit carry-lookahead slices.
// Stage k resolves bits [k*GROUP +: GROUP]; the slice carry ripples to the next
// stage through its register, while the not-yet-used operand bits travel down
// the pipeline shifted so every stage always consumes the low GROUP bits.
module pipelined_cla_adder #(
   parameter int WIDTH = 8,
   parameter int GROUP = 4
) (
   input logic                  CLK,
   input logic                  RST,
   pipelined_cla_adder_if.slave bus
);
   localparam int NSTAGE = (GROUP > 0) ? WIDTH / GROUP : 1;

   // Reject parameter sets that cannot be tiled into whole slices.
   generate
      if ((GROUP < 1) || (GROUP > 8) || (WIDTH < GROUP) ||
          ((WIDTH % ((GROUP > 0) ? GROUP : 1)) != 0)) begin : g_bad_params
         $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP and GROUP must be 1..8");
      end
   endgenerate

   // One lookahead slice: every carry is a flat sum of products of the bit
   // generates/propagates and the slice carry-in. Returns
   // {carry out, carry into slice MSB, sum bits}.
   function automatic logic [GROUP+1:0] cla_slice(
      input logic [GROUP-1:0] a,
      input logic [GROUP-1:0] b,
      input logic             cin
   );
      logic [GROUP-1:0] g;
      logic [GROUP-1:0] p;
      logic [GROUP:0]   c;
      logic             term;
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = cin;
      for (int i = 1; i <= GROUP; i++) begin
         term = cin;
         for (int m = 0; m < i; m++) term = term & p[m];
         c[i] = term;
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int m = j + 1; m < i; m++) term = term & p[m];
            c[i] = c[i] | term;
         end
      end
      return {c[GROUP], c[GROUP-1], p ^ c[GROUP-1:0]};
   endfunction

   // Stage registers.
   logic [WIDTH-1:0] sum_q   [NSTAGE];
   logic [WIDTH-1:0] opa_q   [NSTAGE];
   logic [WIDTH-1:0] opb_q   [NSTAGE];
   logic             carry_q [NSTAGE];
   logic             ovf_q   [NSTAGE];
   logic             valid_q [NSTAGE];

   // Per-stage inputs (what each stage sees before its edge).
   logic [WIDTH-1:0] src_a   [NSTAGE];
   logic [WIDTH-1:0] src_b   [NSTAGE];
   logic [WIDTH-1:0] src_sum [NSTAGE];
   logic             src_c   [NSTAGE];
   logic             src_v   [NSTAGE];

   // Per-stage next values.
   logic [WIDTH-1:0] sum_d   [NSTAGE];
   logic [WIDTH-1:0] opa_d   [NSTAGE];
   logic [WIDTH-1:0] opb_d   [NSTAGE];
   logic             carry_d [NSTAGE];
   logic             ovf_d   [NSTAGE];
   logic             valid_d [NSTAGE];

   // Stage 0 takes the conditioned operands; later stages take the previous stage registers.
   always_comb begin
      src_a[0]   = bus.A;
      src_b[0]   = bus.SUB ? ~bus.B : bus.B;
      src_c[0]   = bus.SUB ? 1'b1 : bus.CI;
      src_sum[0] = '0;
      src_v[0]   = bus.IN_VALID;
      for (int k = 1; k < NSTAGE; k++) begin
         src_a[k]   = opa_q[k-1];
         src_b[k]   = opb_q[k-1];
         src_c[k]   = carry_q[k-1];
         src_sum[k] = sum_q[k-1];
         src_v[k]   = valid_q[k-1];
      end
   end

   // Evaluate each stage's slice and form its register next values.
   always_comb begin
      logic [GROUP+1:0] slice;
      slice = '0;
      for (int k = 0; k < NSTAGE; k++) begin
         slice                      = cla_slice(src_a[k][GROUP-1:0], src_b[k][GROUP-1:0], src_c[k]);
         sum_d[k]                   = src_sum[k];
         sum_d[k][k*GROUP +: GROUP] = slice[GROUP-1:0];
         carry_d[k]                 = slice[GROUP+1];
         // Only the last stage's value is used: there the slice MSB is the word MSB.
         ovf_d[k]                   = slice[GROUP+1] ^ slice[GROUP];
         opa_d[k]                   = src_a[k] >> GROUP;
         opb_d[k]                   = src_b[k] >> GROUP;
         valid_d[k]                 = src_v[k];
      end
   end

   // Pipeline registers: reset clears everything, EN=0 holds everything.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k < NSTAGE; k++) begin
            sum_q[k]   <= '0;
            opa_q[k]   <= '0;
            opb_q[k]   <= '0;
            carry_q[k] <= 1'b0;
            ovf_q[k]   <= 1'b0;
            valid_q[k] <= 1'b0;
         end
      end else if (bus.EN) begin
         for (int k = 0; k < NSTAGE; k++) begin
            sum_q[k]   <= sum_d[k];
            opa_q[k]   <= opa_d[k];
            opb_q[k]   <= opb_d[k];
            carry_q[k] <= carry_d[k];
            ovf_q[k]   <= ovf_d[k];
            valid_q[k] <= valid_d[k];
         end
      end
   end

   assign bus.SUM       = sum_q[NSTAGE-1];
   assign bus.CO        = carry_q[NSTAGE-1];
   assign bus.OVF       = ovf_q[NSTAGE-1];
   assign bus.OUT_VALID = valid_q[NSTAGE-1];
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: an 8/4 instance for reset, vectors, streaming,
// stall, bubble, mid-flight reset and random traffic, plus 4/2 and 4/1
// instances swept exhaustively.
module tb_pipelined_cla_adder;
   localparam int W = 26;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   // Clock generation.
   always #5 CLK = ~CLK;

   pipelined_cla_adder_if #(.WIDTH(8)) b8  ();
   pipelined_cla_adder_if #(.WIDTH(4)) b42 ();
   pipelined_cla_adder_if #(.WIDTH(4)) b41 ();

   pipelined_cla_adder #(.WIDTH(8), .GROUP(4)) dut8  (.CLK(CLK), .RST(RST), .bus(b8));
   pipelined_cla_adder #(.WIDTH(4), .GROUP(2)) dut42 (.CLK(CLK), .RST(RST), .bus(b42));
   pipelined_cla_adder #(.WIDTH(4), .GROUP(1)) dut41 (.CLK(CLK), .RST(RST), .bus(b41));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic       sub;
      logic [7:0] esum;
      logic       eco;
      logic       eovf;
   } vec_t;

   typedef struct {
      logic       rst;
      logic       en;
      logic       iv;
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic       chk;
      logic       ev;
      logic [7:0] esum;
      logic       eco;
   } cyc_t;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         en_cnt = 0;
   logic [W-1:0] exp_q[$];
   cyc_t       seq_q[$];
   vec_t       vt[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic drive8(input logic rst, input logic en, input logic iv,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic sub);
      RST         = rst;
      b8.EN       = en;
      b8.IN_VALID = iv;
      b8.A        = a;
      b8.B        = b;
      b8.CI       = ci;
      b8.SUB      = sub;
   endtask

   task automatic drive4(input logic iv, input logic [3:0] a, input logic [3:0] b,
                         input logic ci, input logic sub);
      b42.EN = 1'b1; b42.IN_VALID = iv; b42.A = a; b42.B = b; b42.CI = ci; b42.SUB = sub;
      b41.EN = 1'b1; b41.IN_VALID = iv; b41.A = a; b41.B = b; b41.CI = ci; b41.SUB = sub;
   endtask

   task automatic add(input logic rst, input logic en, input logic iv,
                      input logic [7:0] a, input logic [7:0] b, input logic sub,
                      input logic chk, input logic ev, input logic [7:0] esum, input logic eco);
      cyc_t c;
      c.rst = rst; c.en = en; c.iv = iv; c.a = a; c.b = b; c.sub = sub;
      c.chk = chk; c.ev = ev; c.esum = esum; c.eco = eco;
      seq_q.push_back(c);
   endtask

   // Reference: plain integer arithmetic on w-bit operands, signed overflow from operand/result signs.
   function automatic logic [9:0] ref_add(input int w, input logic [7:0] a, input logic [7:0] b,
                                          input logic ci, input logic sub);
      int   mask;
      int   bp;
      int   full;
      int   s;
      logic ov;
      mask = (1 << w) - 1;
      bp   = sub ? ((~int'(b)) & mask) : int'(b);
      full = int'(a) + bp + (sub ? 1 : int'(ci));
      s    = full & mask;
      ov   = (a[w-1] == bp[w-1]) && (s[w-1] != a[w-1]);
      return {ov, full[w], s[7:0]};
   endfunction

   function automatic logic [9:0] obs8();
      return {b8.OVF, b8.CO, b8.SUM};
   endfunction

   task automatic sweep_check(input string nm, input int ns, input int j,
                              input logic v, input logic [9:0] obs);
      int   k;
      logic ev;
      k  = j - (ns - 1);
      ev = (k >= 0) && (k < 1024);
      check({nm, "_valid"}, 32'(v), 32'(ev));
      if (ev) check({nm, "_data"}, 32'(obs), 32'(ref_add(4, 8'(k[3:0]), 8'(k[7:4]), k[8], k[9])));
   endtask

   // Stimulus, checking and report.
   initial begin
      logic         r_rst, r_en, r_iv, r_ci, r_sub, ev;
      logic [7:0]   r_a, r_b;
      logic [10:0]  prev;
      logic [W-1:0] e;

      drive8(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      drive4(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

      vt[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      vt[2] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
      vt[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      vt[4] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
      vt[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
      vt[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
      vt[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      vt[8] = '{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
      vt[9] = '{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0};

      // Reset held with live traffic, then the first cycle after release.
      for (int i = 0; i < 3; i++) begin
         drive8(1'b1, 1'b1, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         tick;
         check("rst_hold", {b8.OUT_VALID, obs8()}, 32'h0);
      end
      drive8(1'b0, 1'b1, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      tick;
      check("rst_release", {b8.OUT_VALID, obs8()}, 32'h0);
      drive8(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      tick;

      // Directed vectors: issue, one bubble, result two edges after issue.
      for (int i = 0; i < 10; i++) begin
         drive8(1'b0, 1'b1, 1'b1, vt[i].a, vt[i].b, vt[i].ci, vt[i].sub);
         tick;
         check("vec_gap_slot", 32'(b8.OUT_VALID), 32'h0);
         drive8(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
         tick;
         check("vec_valid", 32'(b8.OUT_VALID), 32'h1);
         check("vec_data", 32'(obs8()), 32'({vt[i].eovf, vt[i].eco, vt[i].esum}));
      end

      // Streaming back-to-back.
      add(0, 1, 0, 8'd0,   8'd0,  0, 0, 0, 8'd0, 0);
      add(0, 1, 1, 8'd1,   8'd2,  0, 0, 0, 8'd0, 0);
      add(0, 1, 1, 8'd3,   8'd4,  0, 1, 1, 8'd3, 0);
      add(0, 1, 1, 8'd250, 8'd10, 0, 1, 1, 8'd7, 0);
      add(0, 1, 0, 8'd0,   8'd0,  0, 1, 1, 8'd4, 1);
      add(0, 1, 0, 8'd0,   8'd0,  0, 0, 0, 8'd0, 0);
      // Two-cycle stall after the second issue.
      add(0, 1, 1, 8'd1,   8'd2,  0, 0, 0, 8'd0, 0);
      add(0, 1, 1, 8'd3,   8'd4,  0, 1, 1, 8'd3, 0);
      add(0, 0, 1, 8'd99,  8'd99, 0, 1, 1, 8'd3, 0);
      add(0, 0, 1, 8'd99,  8'd99, 0, 1, 1, 8'd3, 0);
      add(0, 1, 1, 8'd250, 8'd10, 0, 1, 1, 8'd7, 0);
      add(0, 1, 0, 8'd0,   8'd0,  0, 1, 1, 8'd4, 1);
      add(0, 1, 0, 8'd0,   8'd0,  0, 0, 0, 8'd0, 0);
      // Single bubble between two operations.
      add(0, 1, 1, 8'd1,   8'd2,  0, 0, 0, 8'd0, 0);
      add(0, 1, 0, 8'd55,  8'd55, 0, 1, 1, 8'd3, 0);
      add(0, 1, 1, 8'd3,   8'd4,  0, 0, 0, 8'd0, 0);
      add(0, 1, 0, 8'd0,   8'd0,  0, 1, 1, 8'd7, 0);
      add(0, 1, 0, 8'd0,   8'd0,  0, 0, 0, 8'd0, 0);
      // Reset one cycle after the second issue discards everything in flight.
      add(0, 1, 1, 8'd1,   8'd2,  0, 0, 0, 8'd0, 0);
      add(0, 1, 1, 8'd3,   8'd4,  0, 1, 1, 8'd3, 0);
      add(1, 1, 1, 8'd77,  8'd77, 0, 1, 0, 8'd0, 0);
      add(0, 1, 0, 8'd0,   8'd0,  0, 0, 0, 8'd0, 0);
      add(0, 1, 0, 8'd0,   8'd0,  0, 0, 0, 8'd0, 0);
      add(0, 1, 0, 8'd0,   8'd0,  0, 0, 0, 8'd0, 0);

      foreach (seq_q[i]) begin
         drive8(seq_q[i].rst, seq_q[i].en, seq_q[i].iv, seq_q[i].a, seq_q[i].b, 1'b0, seq_q[i].sub);
         tick;
         check("seq_valid", 32'(b8.OUT_VALID), 32'(seq_q[i].ev));
         if (seq_q[i].chk) check("seq_data", 32'(obs8()), 32'({1'b0, seq_q[i].eco, seq_q[i].esum}));
      end

      // Random traffic with stalls, bubbles and occasional resets; tail drains the pipe.
      for (int n = 0; n < 404; n++) begin
         r_rst = (n < 400) && ($urandom_range(0, 39) == 0);
         r_en  = (n >= 400) || ($urandom_range(0, 4) != 0);
         r_iv  = (n < 400) && ($urandom_range(0, 3) != 0);
         r_a   = 8'($urandom_range(0, 255));
         r_b   = 8'($urandom_range(0, 255));
         r_ci  = 1'($urandom_range(0, 1));
         r_sub = 1'($urandom_range(0, 1));
         prev  = {b8.OUT_VALID, obs8()};
         if (!r_rst && r_en && r_iv) exp_q.push_back({16'(en_cnt + 2), ref_add(8, r_a, r_b, r_ci, r_sub)});
         drive8(r_rst, r_en, r_iv, r_a, r_b, r_ci, r_sub);
         tick;
         if (r_rst) begin
            exp_q.delete();
            check("rnd_reset", {b8.OUT_VALID, obs8()}, 32'h0);
         end else if (!r_en) begin
            check("rnd_stall", {b8.OUT_VALID, obs8()}, 32'(prev));
         end else begin
            en_cnt++;
            ev = (exp_q.size() > 0) && (exp_q[0][25:10] == 16'(en_cnt));
            check("rnd_valid", 32'(b8.OUT_VALID), 32'(ev));
            if (ev) begin
               e = exp_q.pop_front();
               check("rnd_data", 32'(obs8()), 32'(e[9:0]));
            end
         end
      end
      check("rnd_drain", 32'(exp_q.size()), 32'h0);

      // Exhaustive 4-bit sweep, both slice sizes fed the same back-to-back stream.
      drive8(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      for (int j = 0; j < 1024 + 4; j++) begin
         if (j < 1024) drive4(1'b1, j[3:0], j[7:4], j[8], j[9]);
         else          drive4(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
         tick;
         sweep_check("swp_g2", 2, j, b42.OUT_VALID, {b42.OVF, b42.CO, 4'h0, b42.SUM});
         sweep_check("swp_g1", 4, j, b41.OUT_VALID, {b41.OVF, b41.CO, 4'h0, b41.SUM});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
